// File: rtl/multicycle_ctrl_if.sv
// Shared instruction/data memory port between the sequencing controller and memory.
// Carries the request, address-source select, store strobe and completion handshake.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_sel;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_sel, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_sel, input mem_we, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I sequencing controller: IDLE/FETCH/DECODE/EXEC/MEM/WB/TRAP with a
// memory-handshake watchdog, illegal-opcode and interrupt traps.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master mem,
  input  logic [6:0]        opcode,
  input  logic [2:0]        func3,
  input  logic              branch_taken,
  input  logic              irq,
  output logic              ir_we,
  output logic              pc_we,
  output logic [1:0]        pc_sel,
  output logic [2:0]        imm_type,
  output logic              reg_we,
  output logic [1:0]        wb_sel,
  output logic              csr_we,
  output logic              trap,
  output logic [1:0]        trap_cause,
  output logic [2:0]        state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int CNT_W = $clog2(MEM_TIMEOUT);

  function automatic logic [2:0] imm_fmt(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OP_LUI, OP_AUIPC: return 3'b011;
      OP_BRANCH:        return 3'b010;
      OP_JAL:           return 3'b100;
      OP_STORE:         return 3'b001;
      OP_ALUI:          return (f3 == 3'b001 || f3 == 3'b101) ? 3'b101 : 3'b000;
      default:          return 3'b000;
    endcase
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_ALU, OP_ALUI, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  logic [2:0]       state_nxt;
  logic [1:0]       cause_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             timed_out;
  logic             is_store;
  logic             is_mem_op;

  assign is_store  = (opcode == OP_STORE);
  assign is_mem_op = (opcode == OP_LOAD) || is_store;
  assign timed_out = !mem.mem_ready && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
  assign imm_type  = imm_fmt(opcode, func3);

  always_comb begin
    state_nxt = state;
    cause_nxt = 2'b00;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH: begin
        if (mem.mem_ready) begin
          state_nxt = S_DECODE;
        end else if (timed_out) begin
          state_nxt = S_TRAP;
          cause_nxt = 2'b10;
        end
      end
      S_DECODE: begin
        if (is_legal(opcode)) begin
          state_nxt = S_EXEC;
        end else begin
          state_nxt = S_TRAP;
          cause_nxt = 2'b01;
        end
      end
      S_EXEC: begin
        if (opcode == OP_BRANCH) state_nxt = S_FETCH;
        else if (is_mem_op)      state_nxt = S_MEM;
        else                     state_nxt = S_WB;
      end
      S_MEM: begin
        if (mem.mem_ready) begin
          state_nxt = is_store ? S_FETCH : S_WB;
        end else if (timed_out) begin
          state_nxt = S_TRAP;
          cause_nxt = 2'b10;
        end
      end
      S_WB:     state_nxt = S_FETCH;
      S_TRAP:   state_nxt = S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
    // An instruction boundary is where a pending interrupt is taken; TRAP exit and FETCH waits are exempt.
    if (state_nxt == S_FETCH && state != S_TRAP && state != S_FETCH && irq) begin
      state_nxt = S_TRAP;
      cause_nxt = 2'b11;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      trap_cause <= 2'b00;
    end else begin
      state <= state_nxt;
      if ((state == S_FETCH || state == S_MEM) && !mem.mem_ready) wait_cnt <= wait_cnt + 1'b1;
      else                                                        wait_cnt <= '0;
      if (state_nxt == S_TRAP) trap_cause <= cause_nxt;
    end
  end

  always_comb begin
    mem.mem_req = 1'b0;
    mem.mem_sel = 1'b0;
    mem.mem_we  = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 2'b00;
    reg_we      = 1'b0;
    wb_sel      = 2'b00;
    csr_we      = 1'b0;
    trap        = 1'b0;
    case (state)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        ir_we       = mem.mem_ready;
      end
      S_EXEC: begin
        if (opcode == OP_BRANCH) begin
          pc_we  = 1'b1;
          pc_sel = branch_taken ? 2'b01 : 2'b00;
        end
      end
      S_MEM: begin
        mem.mem_req = 1'b1;
        mem.mem_sel = 1'b1;
        mem.mem_we  = is_store;
        pc_we       = is_store && mem.mem_ready;
      end
      S_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        csr_we = (opcode == OP_SYSTEM);
        case (opcode)
          OP_LOAD:         wb_sel = 2'b01;
          OP_JAL, OP_JALR: wb_sel = 2'b10;
          OP_SYSTEM:       wb_sel = 2'b11;
          default:         wb_sel = 2'b00;
        endcase
        if (opcode == OP_JAL)       pc_sel = 2'b01;
        else if (opcode == OP_JALR) pc_sel = 2'b10;
      end
      S_TRAP: begin
        trap   = 1'b1;
        pc_we  = 1'b1;
        pc_sel = 2'b11;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed and randomized instruction streams checked cycle by
// cycle against an instruction-level procedural model of the sequencing rules.
module tb_multicycle_ctrl;
  localparam int TO = 4;

  localparam logic [6:0] OP_ALU = 7'b0110011, OP_ALUI = 7'b0010011, OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011, OP_BR   = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       branch_taken, irq;
  logic       ir_we, pc_we, reg_we, csr_we, trap;
  logic [1:0] pc_sel, wb_sel, trap_cause;
  logic [2:0] imm_type, state;

  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_cause = 2'b00;
  logic [1:0] pend_cause = 2'b00;
  bit         rnd_irq = 1'b0;
  logic [6:0] ops [10] = '{OP_ALU, OP_ALUI, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYS};

  multicycle_ctrl_if mif ();

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .mem(mif),
    .opcode(opcode), .func3(func3), .branch_taken(branch_taken), .irq(irq),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .imm_type(imm_type),
    .reg_we(reg_we), .wb_sel(wb_sel), .csr_we(csr_we), .trap(trap),
    .trap_cause(trap_cause), .state(state)
  );

  task automatic check_eq(input string tag, input logic [19:0] got, input logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [2:0] imm_exp(input logic [6:0] op, input logic [2:0] f3);
    if (op == OP_LUI || op == OP_AUIPC) return 3'b011;
    if (op == OP_BR)  return 3'b010;
    if (op == OP_JAL) return 3'b100;
    if (op == OP_ST)  return 3'b001;
    if (op == OP_ALUI && (f3 == 3'b001 || f3 == 3'b101)) return 3'b101;
    return 3'b000;
  endfunction

  function automatic bit legal(input logic [6:0] op);
    return op inside {OP_ALU, OP_ALUI, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYS};
  endfunction

  // Packed view: state, req, sel, we, ir_we, pc_we, pc_sel, imm, reg_we, wb_sel, csr_we, trap, cause.
  function automatic logic [19:0] ev(input logic [2:0] st, input logic req, input logic sel,
                                     input logic we, input logic irw, input logic pcw,
                                     input logic [1:0] pcs, input logic rw, input logic [1:0] wbs,
                                     input logic cw, input logic tr);
    return {st, req, sel, we, irw, pcw, pcs, imm_exp(opcode, func3), rw, wbs, cw, tr, exp_cause};
  endfunction

  function automatic logic [19:0] act();
    return {state, mif.mem_req, mif.mem_sel, mif.mem_we, ir_we, pc_we, pc_sel, imm_type,
            reg_we, wb_sel, csr_we, trap, trap_cause};
  endfunction

  function automatic logic noise();
    return rnd_irq ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction

  // Inputs are already applied (posedge+1); sample mid-cycle, then advance one clock.
  task automatic cyc(input string tag, input logic [19:0] e);
    #4;
    check_eq(tag, act(), e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_trap();
    exp_cause = pend_cause;
    irq = rnd_irq ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc("trap", ev(3'd6, 0, 0, 0, 0, 1, 2'b11, 0, 2'b00, 0, 1));
  endtask

  // Runs the not-ready cycles of a memory request; done=1 leaves mem_ready=1 applied for the caller.
  task automatic mem_phase(input bit data, input bit store, input int wait_n, output bit done);
    done = 1'b0;
    for (int k = 0; k < TO; k++) begin
      irq = noise();
      if (k == wait_n) begin
        mif.mem_ready = 1'b1;
        done = 1'b1;
        return;
      end
      mif.mem_ready = 1'b0;
      if (k == TO - 1) pend_cause = 2'b10;
      cyc(data ? "mem_wait" : "fetch_wait",
          ev(data ? 3'd4 : 3'd1, 1, data, data & store, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int fw, input int mw,
                           input bit bt, input bit irq_end);
    bit         ok;
    logic [1:0] wbs, pcs;
    mem_phase(1'b0, 1'b0, fw, ok);
    if (!ok) begin do_trap(); return; end
    cyc("fetch_done", ev(3'd1, 1, 0, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0));
    mif.mem_ready = 1'b0;
    opcode = op;
    func3 = f3;
    branch_taken = 1'($urandom_range(0, 1));
    irq = noise();
    if (!legal(op)) pend_cause = 2'b01;
    cyc("decode", ev(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    if (!legal(op)) begin do_trap(); return; end
    if (op == OP_BR) begin
      branch_taken = bt;
      irq = irq_end;
      if (irq_end) pend_cause = 2'b11;
      cyc("exec_branch", ev(3'd3, 0, 0, 0, 0, 1, bt ? 2'b01 : 2'b00, 0, 2'b00, 0, 0));
      if (irq_end) do_trap();
      return;
    end
    irq = noise();
    cyc("exec", ev(3'd3, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    if (op == OP_LD || op == OP_ST) begin
      mem_phase(1'b1, op == OP_ST, mw, ok);
      if (!ok) begin do_trap(); return; end
      if (op == OP_ST) begin
        irq = irq_end;
        if (irq_end) pend_cause = 2'b11;
        cyc("mem_store", ev(3'd4, 1, 1, 1, 0, 1, 2'b00, 0, 2'b00, 0, 0));
        mif.mem_ready = 1'b0;
        if (irq_end) do_trap();
        return;
      end
      cyc("mem_load", ev(3'd4, 1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
      mif.mem_ready = 1'b0;
    end
    wbs = (op == OP_LD) ? 2'b01 : (op == OP_JAL || op == OP_JALR) ? 2'b10 : (op == OP_SYS) ? 2'b11 : 2'b00;
    pcs = (op == OP_JAL) ? 2'b01 : (op == OP_JALR) ? 2'b10 : 2'b00;
    irq = irq_end;
    if (irq_end) pend_cause = 2'b11;
    cyc("writeback", ev(3'd5, 0, 0, 0, 0, 1, pcs, 1, wbs, op == OP_SYS, 0));
    if (irq_end) do_trap();
  endtask

  task automatic do_reset(input bit irq_idle);
    rst_n = 1'b0;
    mif.mem_ready = 1'b0;
    irq = 1'b0;
    #2;
    exp_cause = 2'b00;
    check_eq("reset", act(), ev(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    irq = irq_idle;
    if (irq_idle) pend_cause = 2'b11;
    cyc("idle", ev(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    if (irq_idle) do_trap();
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = OP_ALUI;
    func3 = 3'b000;
    branch_taken = 1'b0;
    irq = 1'b0;
    mif.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset(1'b0);
    run_instr(OP_ALU, 3'b000, 0, 0, 0, 0);
    run_instr(OP_LD, 3'b010, 0, 3, 0, 0);
    run_instr(OP_BR, 3'b000, 0, 0, 1, 0);
    run_instr(7'b0000000, 3'b000, 0, 0, 0, 0);
    run_instr(OP_ALU, 3'b000, TO, 0, 0, 0);
    run_instr(OP_ALUI, 3'b101, TO - 1, 0, 0, 0);
    run_instr(OP_ST, 3'b010, 0, 0, 0, 1);
    run_instr(OP_ST, 3'b010, 1, TO, 0, 0);
    run_instr(OP_JALR, 3'b000, 0, 0, 0, 1);
    run_instr(OP_SYS, 3'b001, 0, 0, 0, 0);
    rnd_irq = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic [6:0] op;
      int fw, mw;
      if (i == 100) do_reset(1'b1);
      op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
      fw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO) : 0;
      mw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO) : 0;
      run_instr(op, 3'($urandom), fw, mw, 1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
